// File: rtl/conv_pkg.sv
// Shared definitions for the sequential 2-D convolution engine: FSM encoding and size helpers.
package conv_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAC   = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Output extent of a valid (no padding) strided window sweep.
  function automatic int unsigned out_dim(input int unsigned in_dim, input int unsigned k,
                                          input int unsigned stride);
    return (in_dim - k) / stride + 1;
  endfunction

  // Counter/address width for n distinct values; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv2d_seq_engine_if.sv
// Result stream of the convolution engine: one requantised pixel plus its address per valid/ready beat.
interface conv2d_seq_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic [DATA_W-1:0] result;
  logic [ADDR_W-1:0] address_out;
  logic              result_valid;
  logic              result_ready;
  logic              result_last;

  modport master (output result, output address_out, output result_valid, output result_last,
                  input result_ready);
  modport slave  (input result, input address_out, input result_valid, input result_last,
                  output result_ready);
endinterface

// File: rtl/conv_requant.sv
// Combinational requantiser: rounding arithmetic right shift, saturation to DATA_W, optional ReLU.
module conv_requant #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 24
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic        [4:0]        shift,
  input  logic                     relu_en,
  output logic        [DATA_W-1:0] result_c
);
  // One guard bit so the rounding add cannot wrap near the top of the accumulator range.
  localparam int unsigned EXT_W = ACC_W + 1;
  localparam int unsigned S_MAX = ACC_W - 1;
  localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SAT_LO = EXT_W'(-(2 ** (DATA_W - 1)));

  logic        [4:0]       s;
  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] rnd;
  logic signed [EXT_W-1:0] q;

  always_comb begin
    s   = (32'(shift) > S_MAX) ? 5'(S_MAX) : shift;
    ext = EXT_W'(acc);
    rnd = (s == 5'd0) ? '0 : (EXT_W'(1) <<< (s - 5'd1));
    q   = (ext + rnd) >>> s;
    if (q > SAT_HI)      result_c = SAT_HI[DATA_W-1:0];
    else if (q < SAT_LO) result_c = SAT_LO[DATA_W-1:0];
    else                 result_c = q[DATA_W-1:0];
    if (relu_en && result_c[DATA_W-1]) result_c = '0;
  end

endmodule

// File: rtl/conv2d_seq_engine.sv
// Sequential multi-channel, multi-filter valid 2-D convolution: one MAC per cycle, bias, requantise,
// and stream each output pixel with its address over a valid/ready interface.
module conv2d_seq_engine
  import conv_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned HEIGHT  = 8,
  parameter int unsigned CHANNEL = 1,
  parameter int unsigned FILTER  = 4,
  parameter int unsigned KSIZE   = 3,
  parameter int unsigned STRIDE  = 1,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_W   = 24
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic                                         relu_en,
  input  logic [4:0]                                   shift,
  input  logic [DATA_W*WIDTH*HEIGHT*CHANNEL-1:0]       indata,
  input  logic [DATA_W*FILTER*KSIZE*KSIZE*CHANNEL-1:0] filterWeight,
  input  logic [ACC_W*FILTER-1:0]                      bias,
  conv2d_seq_engine_if.master                          res,
  output logic                                         busy,
  output logic                                         finish
);
  localparam int unsigned OUT_W   = out_dim(WIDTH, KSIZE, STRIDE);
  localparam int unsigned OUT_H   = out_dim(HEIGHT, KSIZE, STRIDE);
  localparam int unsigned NMAC    = KSIZE * KSIZE * CHANNEL;
  localparam int unsigned NOUT    = FILTER * OUT_H * OUT_W;
  localparam int unsigned ADDR_W  = addr_w(NOUT);
  localparam int unsigned K_W     = addr_w(KSIZE);
  localparam int unsigned C_W     = addr_w(CHANNEL);
  localparam int unsigned X_W     = addr_w(OUT_W);
  localparam int unsigned Y_W     = addr_w(OUT_H);
  localparam int unsigned F_W     = addr_w(FILTER);
  localparam int unsigned IN_BITS = DATA_W * WIDTH * HEIGHT * CHANNEL;
  localparam int unsigned WT_BITS = DATA_W * FILTER * NMAC;
  localparam int unsigned B_BITS  = ACC_W * FILTER;

  localparam logic [K_W-1:0] K_LAST = K_W'(KSIZE - 1);
  localparam logic [C_W-1:0] C_LAST = C_W'(CHANNEL - 1);
  localparam logic [X_W-1:0] X_LAST = X_W'(OUT_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(OUT_H - 1);
  localparam logic [F_W-1:0] F_LAST = F_W'(FILTER - 1);

  logic [STATE_W-1:0] state, state_d;
  logic [IN_BITS-1:0] in_q;
  logic [WT_BITS-1:0] w_q;
  logic [B_BITS-1:0]  bias_q;
  logic [4:0]         shift_q;
  logic               relu_q;

  logic [K_W-1:0]     kx, ky;
  logic [C_W-1:0]     c;
  logic [X_W-1:0]     ox, ox_n;
  logic [Y_W-1:0]     oy, oy_n;
  logic [F_W-1:0]     f, f_n;
  logic [ADDR_W-1:0]  addr_cnt;
  logic signed [ACC_W-1:0] acc, bias_nxt;

  logic               launch, mac_en, load, accept, mac_last, out_last;
  logic [31:0]        pix_idx, wgt_idx;
  logic signed [DATA_W-1:0]   px, wt;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]  rq_c;

  // FSM next state and per-cycle datapath enables.
  always_comb begin
    state_d  = state;
    launch   = 1'b0;
    mac_en   = 1'b0;
    load     = 1'b0;
    accept   = res.result_valid && res.result_ready;
    mac_last = (kx == K_LAST) && (ky == K_LAST) && (c == C_LAST);
    out_last = (ox == X_LAST) && (oy == Y_LAST) && (f == F_LAST);
    case (state)
      S_IDLE:  if (start) begin launch = 1'b1; state_d = S_MAC; end
      S_MAC:   begin mac_en = 1'b1; if (mac_last) state_d = S_WRITE; end
      S_WRITE: if (!res.result_valid || res.result_ready) begin
                 load    = 1'b1;
                 state_d = out_last ? S_FLUSH : S_MAC;
               end
      S_FLUSH: if (accept) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Operand fetch for the current window tap.
  always_comb begin
    pix_idx = (32'(c) * HEIGHT + 32'(oy) * STRIDE + 32'(ky)) * WIDTH + 32'(ox) * STRIDE + 32'(kx);
    wgt_idx = ((32'(f) * CHANNEL + 32'(c)) * KSIZE + 32'(ky)) * KSIZE + 32'(kx);
    px      = DATA_W'(in_q >> (pix_idx * DATA_W));
    wt      = DATA_W'(w_q >> (wgt_idx * DATA_W));
    prod    = px * wt;
  end

  // Next output position (ox fastest, then oy, then f) and the bias that seeds its accumulation.
  always_comb begin
    ox_n = ox + 1'b1;
    oy_n = oy;
    f_n  = f;
    if (ox == X_LAST) begin
      ox_n = '0;
      oy_n = oy + 1'b1;
      if (oy == Y_LAST) begin
        oy_n = '0;
        f_n  = (f == F_LAST) ? '0 : f + 1'b1;
      end
    end
    bias_nxt = ACC_W'(bias_q >> (32'(f_n) * ACC_W));
  end

  conv_requant #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_requant (
    .acc      (acc),
    .shift    (shift_q),
    .relu_en  (relu_q),
    .result_c (rq_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q  <= '0; w_q <= '0; bias_q <= '0; shift_q <= '0; relu_q <= 1'b0;
      kx    <= '0; ky  <= '0; c <= '0; ox <= '0; oy <= '0; f <= '0;
      addr_cnt <= '0;
      acc   <= '0;
      res.result       <= '0;
      res.address_out  <= '0;
      res.result_valid <= 1'b0;
      res.result_last  <= 1'b0;
      busy   <= 1'b0;
      finish <= 1'b0;
    end else begin
      busy   <= (state_d != S_IDLE);
      finish <= (state_d == S_DONE);
      if (launch) begin
        in_q  <= indata; w_q <= filterWeight; bias_q <= bias;
        shift_q <= shift; relu_q <= relu_en;
        kx <= '0; ky <= '0; c <= '0; ox <= '0; oy <= '0; f <= '0;
        addr_cnt <= '0;
        acc <= bias[ACC_W-1:0];
      end else if (mac_en) begin
        acc <= acc + ACC_W'(prod);
        if (kx == K_LAST) begin
          kx <= '0;
          if (ky == K_LAST) begin
            ky <= '0;
            c  <= (c == C_LAST) ? '0 : c + 1'b1;
          end else begin
            ky <= ky + 1'b1;
          end
        end else begin
          kx <= kx + 1'b1;
        end
      end else if (load) begin
        ox <= ox_n; oy <= oy_n; f <= f_n;
        addr_cnt <= addr_cnt + 1'b1;
        acc <= bias_nxt;
      end
      // Output register: reload wins over the drop caused by a same-cycle accept.
      if (load) begin
        res.result       <= rq_c;
        res.address_out  <= addr_cnt;
        res.result_last  <= out_last;
        res.result_valid <= 1'b1;
      end else if (accept) begin
        res.result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_seq_engine.sv
// Directed bench for conv2d_seq_engine over three configurations: 3x3 single window, defaults, strided multichannel.
module tb_conv2d_seq_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int         img[64];
  int         wgt[288];
  int         bia[4];
  int         exp_q[$];
  logic [7:0] got_res[$];
  int         got_addr[$];
  bit         got_last[$];

  // Instance A: 3x3 image, 3x3 kernel, one filter.
  logic a_start = 1'b0, a_relu = 1'b0, a_busy, a_finish;
  logic [4:0]  a_shift = '0;
  logic [71:0] a_indata = '0, a_w = '0;
  logic [23:0] a_bias = '0;
  conv2d_seq_engine_if #(.DATA_W(8), .ADDR_W(1)) a_if ();
  conv2d_seq_engine #(.WIDTH(3), .HEIGHT(3), .CHANNEL(1), .FILTER(1), .KSIZE(3), .STRIDE(1),
                      .DATA_W(8), .ACC_W(24)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .relu_en(a_relu), .shift(a_shift),
    .indata(a_indata), .filterWeight(a_w), .bias(a_bias), .res(a_if.master),
    .busy(a_busy), .finish(a_finish));

  // Instance B: default parameters, 144 outputs.
  logic b_start = 1'b0, b_relu = 1'b0, b_busy, b_finish;
  logic [4:0]   b_shift = '0;
  logic [511:0] b_indata = '0;
  logic [287:0] b_w = '0;
  logic [95:0]  b_bias = '0;
  conv2d_seq_engine_if #(.DATA_W(8), .ADDR_W(8)) b_if ();
  conv2d_seq_engine u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .relu_en(b_relu), .shift(b_shift),
    .indata(b_indata), .filterWeight(b_w), .bias(b_bias), .res(b_if.master),
    .busy(b_busy), .finish(b_finish));

  // Instance C: 5x5, two channels, two filters, stride 2.
  logic c_start = 1'b0, c_relu = 1'b0, c_busy, c_finish;
  logic [4:0]   c_shift = '0;
  logic [399:0] c_indata = '0;
  logic [287:0] c_w = '0;
  logic [47:0]  c_bias = '0;
  conv2d_seq_engine_if #(.DATA_W(8), .ADDR_W(3)) c_if ();
  conv2d_seq_engine #(.WIDTH(5), .HEIGHT(5), .CHANNEL(2), .FILTER(2), .KSIZE(3), .STRIDE(2),
                      .DATA_W(8), .ACC_W(24)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .relu_en(c_relu), .shift(c_shift),
    .indata(c_indata), .filterWeight(c_w), .bias(c_bias), .res(c_if.master),
    .busy(c_busy), .finish(c_finish));

  function automatic int model_requant(input longint acc, input int sh, input bit relu);
    int s;
    longint r;
    s = (sh > 23) ? 23 : sh;
    r = (s != 0) ? ((acc + (64'sd1 <<< (s - 1))) >>> s) : acc;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    if (relu && r < 0) r = 0;
    return int'(r);
  endfunction

  // Reference convolution straight from the definition, in address order.
  task automatic golden(input int w, input int h, input int ch, input int nf, input int k,
                        input int st, input int sh, input bit relu);
    int ow, oh;
    longint acc;
    ow = (w - k) / st + 1;
    oh = (h - k) / st + 1;
    exp_q.delete();
    for (int fi = 0; fi < nf; fi++)
      for (int y = 0; y < oh; y++)
        for (int x = 0; x < ow; x++) begin
          acc = bia[fi];
          for (int ci = 0; ci < ch; ci++)
            for (int ky = 0; ky < k; ky++)
              for (int kx = 0; kx < k; kx++)
                acc += longint'(img[(ci * h + y * st + ky) * w + x * st + kx]) *
                       longint'(wgt[((fi * ch + ci) * k + ky) * k + kx]);
          exp_q.push_back(model_requant(acc, sh, relu));
        end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 64; i++)  img[i] = i - 32;
    for (int i = 0; i < 36; i++)  wgt[i] = (i % 7) - 3;
    for (int f = 0; f < 4; f++)   bia[f] = f * 100 - 150;
  endtask

  task automatic pack_b();
    for (int i = 0; i < 64; i++) b_indata[i*8 +: 8] = 8'(img[i]);
    for (int i = 0; i < 36; i++) b_w[i*8 +: 8] = 8'(wgt[i]);
    for (int f = 0; f < 4; f++)  b_bias[f*24 +: 24] = 24'(bia[f]);
  endtask

  task automatic run_a(input int px, input int w, input int b, input int sh, input bit relu,
                       output logic [7:0] r, output bit ok);
    for (int i = 0; i < 9; i++) begin
      a_indata[i*8 +: 8] = 8'(px);
      a_w[i*8 +: 8]      = 8'(w);
    end
    a_bias = 24'(b); a_shift = 5'(sh); a_relu = relu;
    a_if.result_ready = 1'b1;
    a_start = 1'b1; @(posedge clk); #1; a_start = 1'b0;
    ok = 1'b0; r = 'x;
    for (int cyc = 0; cyc < 40 && !ok; cyc++) begin
      if (a_if.result_valid) r = a_if.result;
      @(posedge clk); #1;
      if (a_finish) ok = 1'b1;
    end
    a_if.result_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  // Records every accepted beat until finish or budget; optionally pokes start and scrambles inputs mid-run.
  task automatic collect_b(input int budget, input int poke, output bit fin);
    got_res.delete(); got_addr.delete(); got_last.delete();
    fin = 1'b0;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      if (b_if.result_valid && b_if.result_ready) begin
        got_res.push_back(b_if.result);
        got_addr.push_back(int'(b_if.address_out));
        got_last.push_back(b_if.result_last);
      end
      if (cyc == poke) begin b_start = 1'b1; b_indata = ~b_indata; end
      else b_start = 1'b0;
      @(posedge clk); #1;
      if (b_finish) fin = 1'b1;
    end
    b_start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic collect_c(input int budget, output bit fin);
    got_res.delete(); got_addr.delete(); got_last.delete();
    fin = 1'b0;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      if (c_if.result_valid && c_if.result_ready) begin
        got_res.push_back(c_if.result);
        got_addr.push_back(int'(c_if.address_out));
        got_last.push_back(c_if.result_last);
      end
      @(posedge clk); #1;
      if (c_finish) fin = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (a_if.result_valid !== 1'b0 || b_if.result_valid !== 1'b0 || c_if.result_valid !== 1'b0 ||
        b_if.result !== 8'd0 || b_if.address_out !== 8'd0 || b_if.result_last !== 1'b0 ||
        a_busy !== 1'b0 || b_busy !== 1'b0 || c_busy !== 1'b0 || b_finish !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b%b%b res=%h addr=%h busy=%b%b%b fin=%b required all zero",
               a_if.result_valid, b_if.result_valid, c_if.result_valid, b_if.result,
               b_if.address_out, a_busy, b_busy, c_busy, b_finish);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_window();
    for (int i = 0; i < 9; i++) begin a_indata[i*8 +: 8] = 8'd1; a_w[i*8 +: 8] = 8'd1; end
    a_bias = '0; a_shift = '0; a_relu = 1'b0; a_if.result_ready = 1'b0;
    a_start = 1'b1; @(posedge clk); #1; a_start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 9) begin
        n_tests++;
        if (a_if.result_valid !== 1'b0 || a_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL early_valid: valid=%b busy=%b required valid=0 busy=1", a_if.result_valid, a_busy);
        end
      end
    end
    n_tests++;
    if (a_if.result_valid !== 1'b1 || a_if.result !== 8'd9 || a_if.address_out !== 1'b0 ||
        a_if.result_last !== 1'b1) begin
      n_fail++;
      $display("FAIL first_result: valid=%b res=%0d addr=%0d last=%b required 1 9 0 1",
               a_if.result_valid, a_if.result, a_if.address_out, a_if.result_last);
    end
    a_if.result_ready = 1'b1;
    @(posedge clk); #1;
    a_if.result_ready = 1'b0;
    n_tests++;
    if (a_finish !== 1'b1 || a_if.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL finish_pulse: finish=%b valid=%b required 1 0", a_finish, a_if.result_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if (a_finish !== 1'b0 || a_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_idle: finish=%b busy=%b required 0 0", a_finish, a_busy);
    end
  endtask

  task automatic test_saturate_relu();
    logic [7:0] r;
    bit ok;
    run_a(127, 127, 0, 0, 1'b0, r, ok);
    n_tests++;
    if (!ok || r !== 8'd127) begin n_fail++; $display("FAIL sat_pos: got %0d ok=%b required 127", $signed(r), ok); end
    run_a(127, -127, 0, 0, 1'b0, r, ok);
    n_tests++;
    if (!ok || r !== 8'h80) begin n_fail++; $display("FAIL sat_neg: got %0d ok=%b required -128", $signed(r), ok); end
    run_a(127, -127, 0, 0, 1'b1, r, ok);
    n_tests++;
    if (!ok || r !== 8'd0) begin n_fail++; $display("FAIL relu: got %0d ok=%b required 0", $signed(r), ok); end
  endtask

  task automatic test_requant_round();
    logic [7:0] r;
    bit ok;
    run_a(1, 0, 5, 1, 1'b0, r, ok);
    n_tests++;
    if (!ok || r !== 8'd3) begin n_fail++; $display("FAIL round_pos: got %0d ok=%b required 3", $signed(r), ok); end
    run_a(1, 0, -5, 1, 1'b0, r, ok);
    n_tests++;
    if (!ok || r !== 8'hFE) begin n_fail++; $display("FAIL round_neg: got %0d ok=%b required -2", $signed(r), ok); end
    run_a(1, 0, 5, 31, 1'b0, r, ok);
    n_tests++;
    if (!ok || r !== 8'd0) begin n_fail++; $display("FAIL shift_clamp_pos: got %0d ok=%b required 0", $signed(r), ok); end
    run_a(1, 0, -5000000, 31, 1'b0, r, ok);
    n_tests++;
    if (!ok || r !== 8'hFF) begin n_fail++; $display("FAIL shift_clamp_neg: got %0d ok=%b required -1", $signed(r), ok); end
  endtask

  task automatic test_stall_and_stream();
    logic [7:0] r0, a0;
    bit stable, seen, fin;
    fill_ramp(); pack_b(); golden(8, 8, 1, 4, 3, 1, 2, 1'b0);
    b_shift = 5'd2; b_relu = 1'b0; b_if.result_ready = 1'b0;
    b_start = 1'b1; @(posedge clk); #1; b_start = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 100 && !seen; cyc++) begin @(posedge clk); #1; seen = b_if.result_valid; end
    r0 = b_if.result; a0 = b_if.address_out;
    n_tests++;
    if (!seen || r0 !== 8'(exp_q[0]) || a0 !== 8'd0) begin
      n_fail++;
      $display("FAIL stall_first: valid=%b res=%0d addr=%0d required 1 %0d 0", seen, $signed(r0), a0, exp_q[0]);
    end
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (b_if.result !== r0 || b_if.address_out !== a0 || b_if.result_valid !== 1'b1 ||
          b_if.result_last !== 1'b0) stable = 1'b0;
    end
    n_tests++;
    if (!stable) begin
      n_fail++;
      $display("FAIL stall_hold: res=%0d addr=%0d valid=%b required res=%0d addr=%0d valid=1",
               b_if.result, b_if.address_out, b_if.result_valid, r0, a0);
    end
    b_if.result_ready = 1'b1;
    collect_b(3000, -1, fin);
    n_tests++;
    if (!fin || got_res.size() != 144) begin
      n_fail++; $display("FAIL stream_count: got %0d finish=%b required 144 1", got_res.size(), fin);
    end
    for (int i = 0; i < got_res.size() && i < 144; i++) begin
      n_tests++;
      if (got_res[i] !== 8'(exp_q[i]) || got_addr[i] != i || got_last[i] != (i == 143)) begin
        n_fail++;
        $display("FAIL stream[%0d]: res=%0d addr=%0d last=%b required %0d %0d %b",
                 i, $signed(got_res[i]), got_addr[i], got_last[i], exp_q[i], i, i == 143);
      end
    end
  endtask

  task automatic test_start_and_abort();
    bit fin, quiet;
    fill_ramp(); pack_b(); golden(8, 8, 1, 4, 3, 1, 2, 1'b0);
    b_shift = 5'd2; b_relu = 1'b0; b_if.result_ready = 1'b1;
    b_start = 1'b1; @(posedge clk); #1; b_start = 1'b0;
    collect_b(3000, 20, fin);
    n_tests++;
    if (!fin || got_res.size() != 144) begin
      n_fail++; $display("FAIL restart_count: got %0d finish=%b required 144 1", got_res.size(), fin);
    end
    for (int i = 0; i < got_res.size() && i < 144; i++) begin
      n_tests++;
      if (got_res[i] !== 8'(exp_q[i]) || got_addr[i] != i) begin
        n_fail++;
        $display("FAIL restart[%0d]: res=%0d addr=%0d required %0d %0d", i, $signed(got_res[i]), got_addr[i], exp_q[i], i);
      end
    end
    pack_b();
    b_start = 1'b1; @(posedge clk); #1; b_start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (b_if.result_valid !== 1'b0 || b_busy !== 1'b0 || b_if.result !== 8'd0 || b_if.address_out !== 8'd0) begin
      n_fail++;
      $display("FAIL abort_reset: valid=%b busy=%b res=%h addr=%h required all zero",
               b_if.result_valid, b_busy, b_if.result, b_if.address_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (b_finish || b_if.result_valid || b_busy) quiet = 1'b0;
    end
    n_tests++;
    if (!quiet) begin n_fail++; $display("FAIL abort_quiet: activity after reset, required none"); end
    b_start = 1'b1; @(posedge clk); #1; b_start = 1'b0;
    collect_b(3000, -1, fin);
    n_tests++;
    if (!fin || got_res.size() != 144) begin
      n_fail++; $display("FAIL rerun_count: got %0d finish=%b required 144 1", got_res.size(), fin);
    end
    for (int i = 0; i < got_res.size() && i < 144; i++) begin
      n_tests++;
      if (got_res[i] !== 8'(exp_q[i]) || got_addr[i] != i || got_last[i] != (i == 143)) begin
        n_fail++;
        $display("FAIL rerun[%0d]: res=%0d addr=%0d last=%b required %0d %0d %b",
                 i, $signed(got_res[i]), got_addr[i], got_last[i], exp_q[i], i, i == 143);
      end
    end
    b_if.result_ready = 1'b0;
  endtask

  task automatic test_stride_multichannel();
    bit fin;
    for (int i = 0; i < 50; i++) img[i] = (i % 11) - 5;
    for (int i = 0; i < 36; i++) wgt[i] = (i % 5) - 2;
    bia[0] = -3; bia[1] = 4;
    for (int i = 0; i < 50; i++) c_indata[i*8 +: 8] = 8'(img[i]);
    for (int i = 0; i < 36; i++) c_w[i*8 +: 8] = 8'(wgt[i]);
    for (int f = 0; f < 2; f++)  c_bias[f*24 +: 24] = 24'(bia[f]);
    golden(5, 5, 2, 2, 3, 2, 1, 1'b0);
    c_shift = 5'd1; c_relu = 1'b0; c_if.result_ready = 1'b1;
    c_start = 1'b1; @(posedge clk); #1; c_start = 1'b0;
    collect_c(500, fin);
    n_tests++;
    if (!fin || got_res.size() != 8) begin
      n_fail++; $display("FAIL stride_count: got %0d finish=%b required 8 1", got_res.size(), fin);
    end
    for (int i = 0; i < got_res.size() && i < 8; i++) begin
      n_tests++;
      if (got_res[i] !== 8'(exp_q[i]) || got_addr[i] != i || got_last[i] != (i == 7)) begin
        n_fail++;
        $display("FAIL stride[%0d]: res=%0d addr=%0d last=%b required %0d %0d %b",
                 i, $signed(got_res[i]), got_addr[i], got_last[i], exp_q[i], i, i == 7);
      end
    end
    n_tests++;
    if (c_busy !== 1'b0 || c_finish !== 1'b0) begin
      n_fail++; $display("FAIL stride_idle: busy=%b finish=%b required 0 0", c_busy, c_finish);
    end
    c_if.result_ready = 1'b0;
  endtask

  initial begin
    a_if.result_ready = 1'b0;
    b_if.result_ready = 1'b0;
    c_if.result_ready = 1'b0;
    test_reset();
    test_single_window();
    test_saturate_relu();
    test_requant_round();
    test_stall_and_stream();
    test_start_and_abort();
    test_stride_multichannel();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
